column_flattener: RTL and testbench
===================================

# column_flattener

Converts per-column DDA ray results into the flat, pixel-by-pixel write stream consumed by the double-buffered frame buffer. It accepts one column descriptor per handshake: column index, wall line height, wall colour and side flag. For that column it emits all 180 rows (ceiling, wall, floor) as RGB565 pixels, each with its flat 320x180 address. After the frame's last column it marks the final pixel, then stalls until the frame buffer reports a buffer swap.

## Interface
Parameters:
- SCREEN_WIDTH, 320: columns per frame; address row stride.
- SCREEN_HEIGHT, 180: rows per column.
- CEILING_COLOR, 16'h39E7: RGB565 colour for rows above the wall.
- FLOOR_COLOR, 16'h7BEF: RGB565 colour for rows below the wall.

Ports:
- pixel_clk_in  input  1  single clock; all logic on rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- dda_valid_in  input  1  column descriptor valid.
- dda_ready_out  output  1  block can accept a descriptor.
- dda_col_in  input  9  column index, 0..SCREEN_WIDTH-1; arrival order is arbitrary.
- dda_line_height_in  input  8  wall height in rows; 0 means no wall.
- dda_color_in  input  16  RGB565 wall colour.
- dda_side_in  input  1  1 = shaded face (darken).
- dda_last_col_in  input  1  this descriptor is the last column of the frame.
- frame_swap_in  input  1  one-cycle pulse: frame buffer has swapped buffers.
- ray_address_out  output  16  flat address, row*SCREEN_WIDTH + col.
- ray_pixel_out  output  16  RGB565 pixel.
- ray_valid_out  output  1  address/pixel pair valid this cycle.
- ray_last_pixel_out  output  1  final pixel of the frame (row 179 of the last column).

## Operation
- FSM states: IDLE, DRAW, WAIT_SWAP. Reset enters IDLE.
- dda_ready_out = (state == IDLE). It is combinational from state only.
- Handshake: dda_valid_in && dda_ready_out at a rising edge. On handshake the block latches all dda_* fields, sets row=0 and base address = col, and enters DRAW.
- Height clamp: h = min(dda_line_height_in, SCREEN_HEIGHT).
- Wall span: draw_start = (SCREEN_HEIGHT - h) >> 1; draw_end = draw_start + h (exclusive). Both are computed once at latch time into 8-bit registers.
- Pixel for row r:
  - r < draw_start: CEILING_COLOR.
  - draw_start <= r < draw_end: wall colour.
  - r >= draw_end: FLOOR_COLOR.
  - With h = 0 there is no wall row.
- Wall colour: dda_color_in. If dda_side_in = 1, each channel is shifted right by 1, giving {1'b0,R[4:1], 1'b0,G[5:1], 1'b0,B[4:1]}.
- Address generation: the address starts at col and adds SCREEN_WIDTH per row. No multiplier. The maximum value is 57599, which fits in 16 bits.
- DRAW: one pixel is emitted per cycle, rows 0..179 in order. After row 179 the next state is:
  - WAIT_SWAP if the latched last flag is set;
  - IDLE otherwise.
- WAIT_SWAP: dda_ready_out = 0. frame_swap_in = 1 at an edge returns the FSM to IDLE. frame_swap_in in IDLE or DRAW is ignored.
- Idle outputs: when ray_valid_out = 0, ray_address_out and ray_pixel_out hold their last values. The frame buffer writes every cycle, so the held pair rewrites identical data harmlessly.
- Reset mid-operation: the in-flight column is abandoned, and all outputs and the FSM return to reset values asynchronously.

## Timing
- Reset values:
  - dda_ready_out = 1 (IDLE).
  - ray_valid_out = 0, ray_last_pixel_out = 0.
  - ray_address_out = 0, ray_pixel_out = 0.
  - row = 0.
- All outputs except dda_ready_out are registered.
- For a handshake at edge E0, row r appears after edge E0+1+r. ray_valid_out is high for exactly 180 consecutive cycles (E0+1..E0+180).
- The FSM leaves DRAW at edge E0+180. dda_ready_out is therefore high in the same cycle that row 179 is presented.
- The earliest next handshake is at E0+181, so there is one bubble cycle between columns (181 cycles per column).
- ray_last_pixel_out is high for exactly one cycle, coincident with row 179 of a last-flagged column.
- WAIT_SWAP lasts until the first edge with frame_swap_in = 1. The next handshake is possible at the following edge.

## Test plan
- Reset: hold rst_n_in = 0 mid-DRAW, release -> dda_ready_out = 1, ray_valid_out = 0, address 0. The next column starts cleanly.
- Single column: col=5, h=100, color=16'hF800, side=0 -> 180 valid cycles, first at E0+1.
  - Addresses 5, 325, ... 57285.
  - Rows 0-39 CEILING_COLOR, rows 40-139 16'hF800, rows 140-179 FLOOR_COLOR.
- Clamp and zero: h=255 gives all 180 rows wall; h=0 gives rows 0-89 ceiling and rows 90-179 floor. With h=1, only row 89 is wall.
- Shading: color=16'hFFFF, side=1 -> wall pixels 16'h7BEF.
- Back-to-back: valid held high for cols 319 then 0 -> second column's first pixel at E0+182, address 0. ray_valid_out is low for exactly one cycle between the columns.
- Frame end: last_col=1 on col 319 -> ray_last_pixel_out high only at address 57599.
  - dda_ready_out stays 0 until frame_swap_in pulses, then returns to 1 the next cycle.
  - frame_swap_in pulsed during DRAW has no effect.

Source files
------------

// File: rtl/column_flattener_if.sv
// Column descriptor handshake plus flat pixel write stream of the column flattener.
// The slave modport is the flattener's view, the master modport is the driver/observer's view.
interface column_flattener_if;
   logic        dda_valid_in;
   logic        dda_ready_out;
   logic [8:0]  dda_col_in;
   logic [7:0]  dda_line_height_in;
   logic [15:0] dda_color_in;
   logic        dda_side_in;
   logic        dda_last_col_in;
   logic [15:0] ray_address_out;
   logic [15:0] ray_pixel_out;
   logic        ray_valid_out;
   logic        ray_last_pixel_out;

   modport slave (
      input  dda_valid_in, dda_col_in, dda_line_height_in, dda_color_in, dda_side_in,
             dda_last_col_in,
      output dda_ready_out, ray_address_out, ray_pixel_out, ray_valid_out, ray_last_pixel_out
   );

   modport master (
      output dda_valid_in, dda_col_in, dda_line_height_in, dda_color_in, dda_side_in,
             dda_last_col_in,
      input  dda_ready_out, ray_address_out, ray_pixel_out, ray_valid_out, ray_last_pixel_out
   );
endinterface

// File: rtl/column_flattener.sv
// Expands one DDA column descriptor into SCREEN_HEIGHT RGB565 pixels with flat addresses,
// marks the frame's final pixel and then waits for the frame buffer swap.
module column_flattener #(
   parameter int unsigned SCREEN_WIDTH  = 320,
   parameter int unsigned SCREEN_HEIGHT = 180,
   parameter logic [15:0] CEILING_COLOR = 16'h39E7,
   parameter logic [15:0] FLOOR_COLOR   = 16'h7BEF
) (
   input  logic               pixel_clk_in,
   input  logic               rst_n_in,
   input  logic               frame_swap_in,
   column_flattener_if.slave  bus
);

   localparam logic [7:0]  LP_HEIGHT = 8'(SCREEN_HEIGHT);
   localparam logic [15:0] LP_WIDTH  = 16'(SCREEN_WIDTH);

   typedef enum logic [1:0] {StIdle, StDraw, StWaitSwap} state_e;

   state_e      r_state;
   logic [7:0]  r_row;
   logic [15:0] r_addr;
   logic [7:0]  r_draw_start;
   logic [7:0]  r_draw_end;
   logic [15:0] r_wall_color;
   logic        r_last;
   logic        r_valid;
   logic        r_last_pixel;
   logic [15:0] r_address_out;
   logic [15:0] r_pixel_out;

   logic        w_handshake;
   logic        w_last_row;
   logic [7:0]  w_height;
   logic [7:0]  w_draw_start;
   logic [7:0]  w_draw_end;
   logic [15:0] w_shaded;
   logic [15:0] w_pixel;

   assign bus.dda_ready_out      = (r_state == StIdle);
   assign bus.ray_address_out    = r_address_out;
   assign bus.ray_pixel_out      = r_pixel_out;
   assign bus.ray_valid_out      = r_valid;
   assign bus.ray_last_pixel_out = r_last_pixel;

   assign w_handshake = bus.dda_valid_in && (r_state == StIdle);
   assign w_last_row  = (r_row == LP_HEIGHT - 8'd1);

   // Wall span is centred vertically; an odd leftover row goes to the floor.
   always_comb begin
      w_height     = (bus.dda_line_height_in > LP_HEIGHT) ? LP_HEIGHT : bus.dda_line_height_in;
      w_draw_start = (LP_HEIGHT - w_height) >> 1;
      w_draw_end   = w_draw_start + w_height;
      w_shaded     = bus.dda_color_in;
      if (bus.dda_side_in) begin
         w_shaded = {1'b0, bus.dda_color_in[15:12], 1'b0, bus.dda_color_in[10:6],
                     1'b0, bus.dda_color_in[4:1]};
      end
   end

   always_comb begin
      w_pixel = FLOOR_COLOR;
      if (r_row < r_draw_start) begin
         w_pixel = CEILING_COLOR;
      end else if (r_row < r_draw_end) begin
         w_pixel = r_wall_color;
      end
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state       <= StIdle;
         r_row         <= 8'd0;
         r_addr        <= 16'd0;
         r_draw_start  <= 8'd0;
         r_draw_end    <= 8'd0;
         r_wall_color  <= 16'd0;
         r_last        <= 1'b0;
         r_valid       <= 1'b0;
         r_last_pixel  <= 1'b0;
         r_address_out <= 16'd0;
         r_pixel_out   <= 16'd0;
      end else begin
         r_valid      <= 1'b0;
         r_last_pixel <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_handshake) begin
                  r_row        <= 8'd0;
                  r_addr       <= {7'd0, bus.dda_col_in};
                  r_draw_start <= w_draw_start;
                  r_draw_end   <= w_draw_end;
                  r_wall_color <= w_shaded;
                  r_last       <= bus.dda_last_col_in;
                  r_state      <= StDraw;
               end
            end
            StDraw: begin
               r_valid       <= 1'b1;
               r_address_out <= r_addr;
               r_pixel_out   <= w_pixel;
               r_last_pixel  <= r_last && w_last_row;
               // Row stride by repeated addition keeps the address path multiplier-free.
               r_addr        <= r_addr + LP_WIDTH;
               r_row         <= r_row + 8'd1;
               if (w_last_row) begin
                  r_row   <= 8'd0;
                  r_state <= r_last ? StWaitSwap : StIdle;
               end
            end
            StWaitSwap: begin
               if (frame_swap_in) begin
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_column_flattener.sv
// Directed bench for column_flattener: pixel/address stream per column, clamp, shading,
// back-to-back columns, frame end with swap, and asynchronous reset mid-column.
module tb_column_flattener;

   localparam logic [15:0] CEIL  = 16'h39E7;
   localparam logic [15:0] FLOOR = 16'h7BEF;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic swap  = 1'b0;

   int unsigned n_vec  = 0;
   int unsigned n_fail = 0;

   column_flattener_if bus ();

   column_flattener dut (
      .pixel_clk_in  (clk),
      .rst_n_in      (rst_n),
      .frame_swap_in (swap),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_pixel(input int r, input int h, input logic [15:0] color,
                                             input logic side);
      int hc, s, e;
      logic [4:0] rc, bc;
      logic [5:0] gc;
      hc = (h > 180) ? 180 : h;
      s  = (180 - hc) / 2;
      e  = s + hc;
      rc = color[15:11];
      gc = color[10:5];
      bc = color[4:0];
      if (side) begin
         rc = rc / 2;
         gc = gc / 2;
         bc = bc / 2;
      end
      if (r < s) return CEIL;
      if (r < e) return {rc, gc, bc};
      return FLOOR;
   endfunction

   task automatic drive_col(input logic [8:0] col, input logic [7:0] h, input logic [15:0] color,
                            input logic side, input logic last);
      bus.dda_col_in         = col;
      bus.dda_line_height_in = h;
      bus.dda_color_in       = color;
      bus.dda_side_in        = side;
      bus.dda_last_col_in    = last;
      bus.dda_valid_in       = 1'b1;
   endtask

   task automatic send(input string tag, input logic [8:0] col, input logic [7:0] h,
                       input logic [15:0] color, input logic side, input logic last);
      @(negedge clk);
      check($sformatf("%s_ready_pre", tag), 32'(bus.dda_ready_out), 32'd1);
      drive_col(col, h, color, side, last);
      @(posedge clk);
      #1 bus.dda_valid_in = 1'b0;
   endtask

   // Call right after the handshake edge; returns at the negedge following row 179.
   task automatic check_pixels(input string tag, input int col, input int h,
                               input logic [15:0] color, input logic side, input logic last);
      for (int r = 0; r < 180; r++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("%s_r%0d_valid", tag, r), 32'(bus.ray_valid_out), 32'd1);
         check($sformatf("%s_r%0d_addr", tag, r), 32'(bus.ray_address_out), 32'(r * 320 + col));
         check($sformatf("%s_r%0d_pix", tag, r), 32'(bus.ray_pixel_out),
               32'(exp_pixel(r, h, color, side)));
         check($sformatf("%s_r%0d_lastpix", tag, r), 32'(bus.ray_last_pixel_out),
               32'(last && r == 179));
         if (r == 0) check($sformatf("%s_r0_ready", tag), 32'(bus.dda_ready_out), 32'd0);
         if (r == 179) check($sformatf("%s_r179_ready", tag), 32'(bus.dda_ready_out), 32'(!last));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.dda_valid_in       = 1'b0;
      bus.dda_col_in         = 9'd0;
      bus.dda_line_height_in = 8'd0;
      bus.dda_color_in       = 16'd0;
      bus.dda_side_in        = 1'b0;
      bus.dda_last_col_in    = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_ready", 32'(bus.dda_ready_out), 32'd1);
      check("rst_valid", 32'(bus.ray_valid_out), 32'd0);
      check("rst_lastpix", 32'(bus.ray_last_pixel_out), 32'd0);
      check("rst_addr", 32'(bus.ray_address_out), 32'd0);
      check("rst_pix", 32'(bus.ray_pixel_out), 32'd0);
      rst_n = 1'b1;

      send("single", 9'd5, 8'd100, 16'hF800, 1'b0, 1'b0);
      check_pixels("single", 5, 100, 16'hF800, 1'b0, 1'b0);
      @(negedge clk);
      check("hold_valid", 32'(bus.ray_valid_out), 32'd0);
      check("hold_addr", 32'(bus.ray_address_out), 32'd57285);
      check("hold_pix", 32'(bus.ray_pixel_out), 32'(FLOOR));

      send("clamp", 9'd10, 8'd255, 16'h07E0, 1'b0, 1'b0);
      check_pixels("clamp", 10, 255, 16'h07E0, 1'b0, 1'b0);
      send("zero", 9'd11, 8'd0, 16'h1234, 1'b0, 1'b0);
      check_pixels("zero", 11, 0, 16'h1234, 1'b0, 1'b0);
      send("one", 9'd12, 8'd1, 16'h001F, 1'b0, 1'b0);
      check_pixels("one", 12, 1, 16'h001F, 1'b0, 1'b0);
      send("shade", 9'd7, 8'd60, 16'hFFFF, 1'b1, 1'b0);
      check_pixels("shade", 7, 60, 16'hFFFF, 1'b1, 1'b0);

      // Valid stays high across both columns.
      @(negedge clk);
      check("b2b_ready_pre", 32'(bus.dda_ready_out), 32'd1);
      drive_col(9'd319, 8'd120, 16'hABCD, 1'b0, 1'b0);
      @(posedge clk);
      #1 drive_col(9'd0, 8'd30, 16'h1234, 1'b1, 1'b0);
      check_pixels("b2b_a", 319, 120, 16'hABCD, 1'b0, 1'b0);
      @(posedge clk);
      #1 bus.dda_valid_in = 1'b0;
      @(negedge clk);
      check("b2b_bubble_valid", 32'(bus.ray_valid_out), 32'd0);
      check("b2b_bubble_ready", 32'(bus.dda_ready_out), 32'd0);
      check_pixels("b2b_b", 0, 30, 16'h1234, 1'b1, 1'b0);

      send("frame", 9'd319, 8'd80, 16'h5555, 1'b0, 1'b1);
      fork
         check_pixels("frame", 319, 80, 16'h5555, 1'b0, 1'b1);
         begin
            repeat (40) @(negedge clk);
            swap = 1'b1;
            @(negedge clk);
            swap = 1'b0;
         end
      join
      repeat (5) @(negedge clk);
      check("wait_ready", 32'(bus.dda_ready_out), 32'd0);
      check("wait_valid", 32'(bus.ray_valid_out), 32'd0);
      check("wait_lastpix", 32'(bus.ray_last_pixel_out), 32'd0);
      swap = 1'b1;
      check("swap_ready_before", 32'(bus.dda_ready_out), 32'd0);
      @(negedge clk);
      swap = 1'b0;
      check("swap_ready_after", 32'(bus.dda_ready_out), 32'd1);

      send("midrst", 9'd20, 8'd100, 16'hF800, 1'b0, 1'b0);
      repeat (50) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_ready", 32'(bus.dda_ready_out), 32'd1);
      check("midrst_valid", 32'(bus.ray_valid_out), 32'd0);
      check("midrst_addr", 32'(bus.ray_address_out), 32'd0);
      check("midrst_pix", 32'(bus.ray_pixel_out), 32'd0);
      check("midrst_lastpix", 32'(bus.ray_last_pixel_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send("after_rst", 9'd3, 8'd100, 16'hF800, 1'b0, 1'b0);
      check_pixels("after_rst", 3, 100, 16'hF800, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
